// File: rtl/mult_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter_if
// Brief    : Request/response/multiplier bundle for mult_share_arbiter.
// Revision : 1.0
// ============================================================================
interface mult_share_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int BIT_WIDTH = 3,
    parameter int OUT_WIDTH = 2 * BIT_WIDTH,
    parameter int ID_W      = 2
) ();
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*BIT_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic [BIT_WIDTH-1:0]         mul_inp;
    logic [OUT_WIDTH-1:0]         mul_out;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [OUT_WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]              rsp_id;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, mul_out, rsp_ready,
        output req_ready, mul_inp, rsp_valid, rsp_data, rsp_id
    );

    // Requesters, multiplier and response consumer side
    modport master (
        output req_valid, req_data, mul_out, rsp_ready,
        input  req_ready, mul_inp, rsp_valid, rsp_data, rsp_id
    );
endinterface
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter
// Brief    : Shares one slow combinational multiplier among NUM_REQ requesters;
//            macro MULT_SHARE_RR_EN selects round-robin instead of fixed priority.
// Revision : 1.0
// ============================================================================
module mult_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BIT_WIDTH  = 3,
    parameter int OUT_WIDTH  = 2 * BIT_WIDTH,
    parameter int SETTLE_CYC = 2,
    parameter int ID_W       = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mult_share_arbiter_if.slave bus
);

    localparam int                CNT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0]  C_CNT_INIT = CNT_W'(SETTLE_CYC - 1);
    localparam logic [ID_W:0]     C_NUM_REQ  = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]   C_LAST     = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] C_ONE     = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [BIT_WIDTH-1:0]   r_mul_inp;
    logic [BIT_WIDTH-1:0]   w_mul_inp_nxt;
    logic [ID_W-1:0]        r_rsp_id;
    logic [ID_W-1:0]        w_rsp_id_nxt;
    logic [OUT_WIDTH-1:0]   r_rsp_data;
    logic [OUT_WIDTH-1:0]   w_rsp_data_nxt;
    logic                   r_rsp_valid;
    logic                   w_rsp_valid_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;

    logic [BIT_WIDTH-1:0]   w_ops [NUM_REQ];
    logic [ID_W-1:0]        w_ptr;
    logic [ID_W:0]          w_idx;
    logic [ID_W-1:0]        w_gnt;
    logic                   w_found;
    logic                   w_accept;
    logic [NUM_REQ-1:0]     w_ready;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_ops[gi] = bus.req_data[gi*BIT_WIDTH +: BIT_WIDTH];
    end

`ifdef MULT_SHARE_RR_EN
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_ptr_nxt;

    // Pointer moves just past the winner so it gets lowest priority next time
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_accept) begin
            w_ptr_nxt = (w_gnt == C_LAST) ? '0 : w_gnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // Circular search from the pointer; with a zero pointer this is plain
    // lowest-index-wins priority.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, w_ptr} + (ID_W + 1)'(k);
            if (w_idx >= C_NUM_REQ) begin
                w_idx = w_idx - C_NUM_REQ;
            end
            if (!w_found && bus.req_valid[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[ID_W-1:0];
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_found && !rst;
    assign w_ready  = w_accept ? (C_ONE << w_gnt) : '0;

    always_comb begin
        w_state_nxt     = r_state;
        w_mul_inp_nxt   = r_mul_inp;
        w_rsp_id_nxt    = r_rsp_id;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_valid_nxt = r_rsp_valid;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_mul_inp_nxt = w_ops[w_gnt];
                    w_rsp_id_nxt  = w_gnt;
                    w_cnt_nxt     = C_CNT_INIT;
                    w_state_nxt   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Operand has been stable SETTLE_CYC cycles when the count hits zero
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_rsp_data_nxt  = bus.mul_out;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_RESP;
                end
            end
            S_RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mul_inp   <= '0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mul_inp   <= w_mul_inp_nxt;
            r_rsp_id    <= w_rsp_id_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.mul_inp   = r_mul_inp;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arbiter
// Brief    : Directed self-checking bench; multiplier modelled as signed square.
// Revision : 1.0
// ============================================================================
module tb_mult_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int BW      = 3;
    localparam int OW      = 6;
    localparam int IDW     = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mult_share_arbiter_if #(.NUM_REQ(NUM_REQ), .BIT_WIDTH(BW), .OUT_WIDTH(OW), .ID_W(IDW)) bus ();

    mult_share_arbiter #(
        .NUM_REQ(NUM_REQ), .BIT_WIDTH(BW), .OUT_WIDTH(OW), .SETTLE_CYC(2), .ID_W(IDW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Multiplier model: signed square of the registered operand
    logic signed [OW-1:0] w_ext;
    assign w_ext       = {{(OW-BW){bus.mul_inp[BW-1]}}, bus.mul_inp};
    assign bus.mul_out = w_ext * w_ext;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = 12'hABC;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.mul_inp !== 3'b000) begin n_fail++; $display("FAIL reset_mul_inp: got %b want 000", bus.mul_inp); end
        n_checks++; if (bus.rsp_data !== 6'd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", bus.rsp_data); end
        n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", bus.rsp_id); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", bus.req_ready); end
        bus.req_valid = '0;
        tick();
        n_checks++; if (bus.mul_inp !== 3'b000) begin n_fail++; $display("FAIL reset_no_accept: mul_inp got %b want 000", bus.mul_inp); end
    endtask

    task automatic test_single();
        do_reset();
        bus.req_valid       = 4'b0001;
        bus.req_data[2:0]   = 3'b101;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_pulse: got %b want 0000", bus.req_ready); end
        n_checks++; if (bus.mul_inp !== 3'b101) begin n_fail++; $display("FAIL single_mul_inp: got %b want 101", bus.mul_inp); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early1: got %b want 0", bus.rsp_valid); end
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early2: got %b want 0", bus.rsp_valid); end
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_data !== 6'b001001) begin n_fail++; $display("FAIL single_data: got %b want 001001", bus.rsp_data); end
        n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d want 0", bus.rsp_id); end
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_release: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.rsp_ready     = 1'b0;
        bus.req_valid     = 4'b0100;
        bus.req_data[8:6] = 3'b100;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_ready: got %b want 0100", bus.req_ready); end
        tick();
        bus.req_valid     = 4'b0001;
        bus.req_data[2:0] = 3'b001;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
            n_checks++; if (bus.rsp_data !== 6'b010000) begin n_fail++; $display("FAIL bp_data[%0d]: got %b want 010000", i, bus.rsp_data); end
            n_checks++; if (bus.rsp_id !== 2'd2) begin n_fail++; $display("FAIL bp_id[%0d]: got %0d want 2", i, bus.rsp_id); end
            n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_no_grant[%0d]: got %b want 0000", i, bus.req_ready); end
            n_checks++; if (bus.mul_inp !== 3'b100) begin n_fail++; $display("FAIL bp_mul_inp[%0d]: got %b want 100", i, bus.mul_inp); end
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_same_cycle_grant: got %b want 0000", bus.req_ready); end
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_next_grant: got %b want 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b want 1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_data !== 6'd1) begin n_fail++; $display("FAIL bp_next_data: got %0d want 1", bus.rsp_data); end
        n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_next_id: got %0d want 0", bus.rsp_id); end
        tick();
    endtask

    task automatic test_all_valid();
        logic [OW-1:0]      sq_req [NUM_REQ];
        logic [IDW-1:0]     exp_id;
        logic [NUM_REQ-1:0] exp_rdy;
        sq_req = '{6'd1, 6'd4, 6'd9, 6'd1};
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = {3'b111, 3'b011, 3'b010, 3'b001};
        for (int n = 0; n < 5; n++) begin
`ifdef MULT_SHARE_RR_EN
            exp_id = IDW'(n % NUM_REQ);
`else
            exp_id = 2'd0;
`endif
            exp_rdy = 4'b0001 << exp_id;
            #1;
            n_checks++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL all_grant[%0d]: got %b want %b", n, bus.req_ready, exp_rdy); end
            tick();
            n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL all_settle1[%0d]: got %b want 0000", n, bus.req_ready); end
            tick();
            n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL all_settle2[%0d]: got %b want 0000", n, bus.req_ready); end
            tick();
            n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL all_valid[%0d]: got %b want 1", n, bus.rsp_valid); end
            n_checks++; if (bus.rsp_id !== exp_id) begin n_fail++; $display("FAIL all_id[%0d]: got %0d want %0d", n, bus.rsp_id, exp_id); end
            n_checks++; if (bus.rsp_data !== sq_req[exp_id]) begin n_fail++; $display("FAIL all_data[%0d]: got %0d want %0d", n, bus.rsp_data, sq_req[exp_id]); end
            n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL all_resp_grant[%0d]: got %b want 0000", n, bus.req_ready); end
            tick();
        end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.req_valid      = 4'b1000;
        bus.req_data[11:9] = 3'b010;
        #1;
        n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_ready: got %b want 1000", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        n_checks++; if (bus.mul_inp !== 3'b010) begin n_fail++; $display("FAIL mid_mul_inp: got %b want 010", bus.mul_inp); end
        rst = 1'b1;
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.mul_inp !== 3'b000) begin n_fail++; $display("FAIL mid_rst_mul_inp: got %b want 000", bus.mul_inp); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp[%0d]: got %b want 0", i, bus.rsp_valid); end
        end
        bus.req_valid     = 4'b0010;
        bus.req_data[5:3] = 3'b011;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_idle_grant: got %b want 0010", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_after_valid: got %b want 1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_data !== 6'd9) begin n_fail++; $display("FAIL mid_after_data: got %0d want 9", bus.rsp_data); end
        n_checks++; if (bus.rsp_id !== 2'd1) begin n_fail++; $display("FAIL mid_after_id: got %0d want 1", bus.rsp_id); end
        tick();
    endtask

    task automatic test_sweep();
        logic [OW-1:0] sq_tab [8];
        logic [BW-1:0] op;
        sq_tab = '{6'd0, 6'd1, 6'd4, 6'd9, 6'd16, 6'd9, 6'd4, 6'd1};
        do_reset();
        for (int v = 0; v < 8; v++) begin
            op                 = BW'(v);
            bus.req_valid      = 4'b1000;
            bus.req_data[11:9] = op;
            #1;
            n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL sweep_ready[%0d]: got %b want 1000", v, bus.req_ready); end
            tick();
            bus.req_valid = '0;
            tick();
            tick();
            n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sweep_valid[%0d]: got %b want 1", v, bus.rsp_valid); end
            n_checks++; if (bus.rsp_data !== sq_tab[v]) begin n_fail++; $display("FAIL sweep_data[%0d]: got %b want %b", v, bus.rsp_data, sq_tab[v]); end
            n_checks++; if (bus.rsp_id !== 2'd3) begin n_fail++; $display("FAIL sweep_id[%0d]: got %0d want 3", v, bus.rsp_id); end
            tick();
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_all_valid();
        test_mid_reset();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Sequential front end that shares one combinational signed 3-bit multiplier instance (`inp` → `out`, OUT_WIDTH = 2*BIT_WIDTH) among several requesters. It arbitrates valid/ready requests and registers the selected operand onto the multiplier input. It then waits a fixed number of settle cycles for the slow printed-technology datapath and returns the registered product with the requester ID on a single response channel. It sits between the requesting units and the multiplier `top` instance.

## Interface

- `NUM_REQ`, default 4: number of requesters, 2..8.
- `BIT_WIDTH`, default 3: operand width, signed.
- `OUT_WIDTH`, default 2*BIT_WIDTH: product width, signed.
- `SETTLE_CYC`, default 2: cycles the multiplier input is held before the output is sampled, minimum 1.
- `ID_W`, default 2: width of `rsp_id`, must satisfy 2^ID_W ≥ NUM_REQ.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request.
- `req_data` in NUM_REQ*BIT_WIDTH: operands; requester i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
- `req_ready` out NUM_REQ: one-hot accept strobe.
- `mul_inp` out BIT_WIDTH: registered operand to the multiplier `inp`.
- `mul_out` in OUT_WIDTH: product from the multiplier `out`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_data` out OUT_WIDTH: registered product.
- `rsp_id` out ID_W: index of the served requester.

## Operation

- The FSM has three states: IDLE, SETTLE, RESP.
- **IDLE**
  - `req_ready[g]` = 1 only for the winner g, and only when `req_valid[g]` = 1. Otherwise `req_ready` = 0.
  - On the accept edge: `mul_inp` ← operand g; `rsp_id` ← g; settle counter ← SETTLE_CYC-1; state ← SETTLE.
- **SETTLE**
  - `mul_inp` is held.
  - While the counter ≠ 0, it decrements.
  - When the counter = 0: `rsp_data` ← `mul_out` with no width change; `rsp_valid` ← 1; state ← RESP.
- **RESP**
  - `rsp_valid`, `rsp_data`, `rsp_id` and `mul_inp` are held.
  - On `rsp_valid && rsp_ready`: `rsp_valid` ← 0; state ← IDLE.
  - No new grant is issued in the same cycle.
- **Requester rules.** Requesters hold `req_valid` and `req_data` stable until accepted. A `req_valid` that drops before acceptance is simply not served.
- `req_ready` is combinational from state, `req_valid` and the priority pointer. It is forced to 0 while `rst` = 1.
- `rsp_valid` can rise only from SETTLE; there are no spurious responses.
- **Reset** (also applies mid-operation, which drops any in-flight operation without a response):
  - state = IDLE
  - `mul_inp` = 0
  - `rsp_valid` = 0
  - `rsp_data` = 0
  - `rsp_id` = 0
  - priority pointer = 0
  - settle counter = 0

## Timing

- Accept in cycle T → `rsp_valid` high from cycle T+SETTLE_CYC+1.
- Earliest next accept is cycle T+SETTLE_CYC+2, when `rsp_ready` is high in the first RESP cycle.
- Peak throughput: one product per SETTLE_CYC+2 cycles.
- `mul_inp` changes only on an accept edge. It is therefore stable for at least SETTLE_CYC full cycles before sampling.
- Back-pressure: `rsp_ready` low holds RESP indefinitely, and no requester is accepted meanwhile.

## Configuration

- `MULT_SHARE_RR_EN` defined: round-robin arbitration.
  - Search starts at the pointer; the first requester with `req_valid` set wins.
  - On accept, the pointer ← (g+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
- `MULT_SHARE_RR_EN` undefined: fixed priority, lowest index wins.
  - The pointer register is not implemented.
  - `req_valid` = all-ones always serves requester 0.

## Test plan

The bench models the multiplier as `mul_out` = `mul_inp` * `mul_inp` (signed), with default parameters.

- **Single request.** Reset, then `req_valid` = 4'b0001 with operand 3'b101 (-3) → `req_ready[0]` pulses for one cycle; `rsp_valid` rises 3 cycles later with `rsp_data` = 6'b001001 (9) and `rsp_id` = 0.
- **Back-pressure.** Operand 3'b100 (-4) on requester 2 with `rsp_ready` low for 5 cycles → `rsp_data` = 6'b010000 (16) and `rsp_id` = 2 held stable; no `req_ready` asserted during the stall; the response is released on the first `rsp_ready` high.
- **All requesters valid (RR).** With `MULT_SHARE_RR_EN`, all four requesters continuously valid → grant order 0,1,2,3,0; each accept is 4 cycles apart with `rsp_ready` tied high.
- **All requesters valid (fixed).** Without the macro, the same stimulus → requester 0 is granted every time.
- **Mid-operation reset.** Assert `rst` in a SETTLE cycle → the next cycle shows `rsp_valid` = 0, `mul_inp` = 0 and state IDLE; no response for the aborted request; a subsequent request completes normally.
- **Exhaustive sweep.** All 8 operands from requester 3 in sequence → `rsp_data` matches the signed square for every value, including 3'b011 → 6'b001001.
